// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types and constants for the memory stage.
//   mem_state_e       - sequencer states of the SRAM access FSM
//   SRAM_DW           - SRAM data-bus width (one half-word)
//   DEFAULT_DATA_BASE - byte address that maps onto SRAM half-word 0
package mem_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } mem_state_e;

  localparam int SRAM_DW = 16;
  localparam logic [31:0] DEFAULT_DATA_BASE = 32'd1024;

endpackage

// File: rtl/sram_controller.sv
// sram_controller: splits one 32-bit access into two half-word SRAM
// transactions (low half, then high half), each held WAIT_CYCLES cycles.
// Ports:
//   clk, rst      - clock, async active-high reset
//   start         - accepted request (already filtered by any fault check)
//   write         - 1 = store, 0 = load (stable while the access runs)
//   hw_index      - word index; half-word address = {hw_index, half}
//   wdata         - store data
//   sram_dq_in    - SRAM read data
//   freeze        - stall for upstream stages
//   sram_addr, sram_dq_out, sram_dq_oe, sram_we_n - SRAM pins
//   mem_data      - captured load data
//   state_dbg     - current FSM state
//
// Handshake: a request is taken when start=1 in IDLE; the requester must
// hold its inputs while freeze=1. The access completes in DONE, where
// freeze=0 so the requester advances on that clock edge.
module sram_controller
  import mem_stage_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               write,
  input  logic [SRAM_AW-2:0] hw_index,
  input  logic [31:0]        wdata,
  input  logic [SRAM_DW-1:0] sram_dq_in,
  output logic               freeze,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_out,
  output logic               sram_dq_oe,
  output logic               sram_we_n,
  output logic [31:0]        mem_data,
  output logic [1:0]         state_dbg
);

  localparam int CW = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WAIT_CYCLES - 1);
  // With a single wait cycle there is no room for a data-hold cycle.
  localparam bit SINGLE = (WAIT_CYCLES == 1);

  mem_state_e    state, state_nx;
  logic [CW-1:0] cnt;
  logic          last;
  logic          busy;

  assign last      = (cnt == LAST_CNT);
  assign busy      = (state == ST_LOW) || (state == ST_HIGH);
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state_nx != state) cnt <= '0;
      else if (busy)         cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start) state_nx = ST_LOW;
      ST_LOW:  if (last)  state_nx = ST_HIGH;
      ST_HIGH: if (last)  state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Reset gates the request term so freeze drops in the reset cycle itself.
  assign freeze = ((state == ST_IDLE) && start && !rst) || busy;

  always_comb begin
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    if (busy) begin
      sram_addr = {hw_index, (state == ST_HIGH)};
      if (write) begin
        sram_dq_oe  = 1'b1;
        sram_dq_out = (state == ST_HIGH) ? wdata[31:16] : wdata[15:0];
        // Last cycle of each half holds data with the strobe released.
        sram_we_n   = SINGLE ? 1'b0 : last;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_data <= '0;
    end else if (!write && last) begin
      if (state == ST_LOW)  mem_data[15:0]  <= sram_dq_in;
      if (state == ST_HIGH) mem_data[31:16] <= sram_dq_in;
    end
  end

endmodule

// File: rtl/mem_stage_sram.sv
// mem_stage_sram: memory stage of the pipeline. Performs 32-bit loads and
// stores on a 16-bit SRAM, stalls upstream with freeze while busy, and
// passes ALU result and write-back controls to MEM/WB combinationally.
// Optional feature macro: MEM_STAGE_ALIGN_CHECK_EN - when defined,
// misaligned or out-of-range requests raise align_err and are not started.
// Ports:
//   clk, rst                                 - clock, async active-high reset
//   mem_read_en, mem_write_en, wb_en_in      - execute-stage controls
//   alu_res, val_Rm, dest_in                 - address/result, store data, dest
//   mem_read_en_out, wb_en, alu_res_out, dest - passthroughs to MEM/WB
//   mem_data                                 - registered load data
//   freeze                                   - stall request
//   sram_addr, sram_dq_out, sram_dq_in, sram_dq_oe, sram_we_n - SRAM pins
//   align_err                                - faulting access flag
//   dbg_state                                - current FSM state
module mem_stage_sram
  import mem_stage_pkg::*;
#(
  parameter logic [31:0] DATA_BASE   = DEFAULT_DATA_BASE,
  parameter int          WAIT_CYCLES = 2,
  parameter int          SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_read_en,
  input  logic               mem_write_en,
  input  logic               wb_en_in,
  input  logic [31:0]        alu_res,
  input  logic [31:0]        val_Rm,
  input  logic [3:0]         dest_in,
  output logic               mem_read_en_out,
  output logic               wb_en,
  output logic [31:0]        alu_res_out,
  output logic [3:0]         dest,
  output logic [31:0]        mem_data,
  output logic               freeze,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n,
  output logic               align_err,
  output logic [1:0]         dbg_state
);

  logic        req;
  logic [31:0] off;
  logic        start;

  assign req = mem_read_en | mem_write_en;
  assign off = alu_res - DATA_BASE;

  assign mem_read_en_out = mem_read_en;
  assign wb_en           = wb_en_in;
  assign alu_res_out     = alu_res;
  assign dest            = dest_in;

`ifdef MEM_STAGE_ALIGN_CHECK_EN
  assign align_err = req & ((off[1:0] != 2'b00) | (alu_res < DATA_BASE) |
                            (off[31:SRAM_AW+1] != '0));
`else
  logic unused_off_bits;
  assign unused_off_bits = ^{off[1:0], off[31:SRAM_AW+1]};
  assign align_err = 1'b0;
`endif

  assign start = req & ~align_err;

  sram_controller #(
    .WAIT_CYCLES(WAIT_CYCLES),
    .SRAM_AW    (SRAM_AW)
  ) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .write      (mem_write_en),
    .hw_index   (off[SRAM_AW:2]),
    .wdata      (val_Rm),
    .sram_dq_in (sram_dq_in),
    .freeze     (freeze),
    .sram_addr  (sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe (sram_dq_oe),
    .sram_we_n  (sram_we_n),
    .mem_data   (mem_data),
    .state_dbg  (dbg_state)
  );

endmodule

// File: tb/tb_mem_stage_sram.sv
module tb_mem_stage_sram;

  localparam int W      = 2;
  localparam int AW     = 18;
  localparam int BASE   = 1024;
  localparam int FRZ    = 1 + 2 * W;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_read_en = 1'b0, mem_write_en = 1'b0, wb_en_in = 1'b0;
  logic [31:0]   alu_res = '0, val_Rm = '0;
  logic [3:0]    dest_in = '0;
  logic          mem_read_en_out, wb_en, freeze, sram_dq_oe, sram_we_n, align_err;
  logic [31:0]   alu_res_out, mem_data;
  logic [3:0]    dest;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_out, sram_dq_in;
  logic [1:0]    dbg_state;

  int errors = 0;
  int checks = 0;

  // SRAM half-word storage and word-level reference model
  logic [15:0] sram_mem [0:1023];
  logic [31:0] ref_word [0:15];
  logic [31:0] last_rd = '0;

  // scoreboard queues
  logic [31:0] exp_q[$];      // expected mem_data at completion
  logic        exp_rd_q[$];   // 1 = load (check data)
  logic [33:0] exp_wr_q[$];   // {half-word address, data} per strobe cycle

  mem_stage_sram #(.DATA_BASE(32'd1024), .WAIT_CYCLES(W), .SRAM_AW(AW)) dut (
    .clk(clk), .rst(rst), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .wb_en_in(wb_en_in), .alu_res(alu_res), .val_Rm(val_Rm), .dest_in(dest_in),
    .mem_read_en_out(mem_read_en_out), .wb_en(wb_en), .alu_res_out(alu_res_out),
    .dest(dest), .mem_data(mem_data), .freeze(freeze), .sram_addr(sram_addr),
    .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe),
    .sram_we_n(sram_we_n), .align_err(align_err), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // SRAM model
  assign sram_dq_in = sram_mem[sram_addr[9:0]];
  always @(posedge clk) begin
    if (!rst && !sram_we_n) sram_mem[sram_addr[9:0]] <= sram_dq_out;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: completion of each access (freeze falls)
  int run = 0;
  always @(negedge clk) begin
    logic [31:0] e;
    logic        r;
    if (rst) begin
      run = 0;
    end else if (freeze) begin
      run++;
    end else if (run > 0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_completion", 32'(run), 32'd0);
      end else begin
        e = exp_q.pop_front();
        r = exp_rd_q.pop_front();
        chk("freeze_len", 32'(run), 32'(FRZ));
        chk("done_state", {30'd0, dbg_state}, {30'd0, S_DONE});
        if (r) chk("load_data", mem_data, e);
      end
      run = 0;
    end
  end

  // monitor: write strobes on the SRAM bus
  always @(negedge clk) begin
    logic [33:0] e;
    if (!rst && !sram_we_n) begin
      if (exp_wr_q.size() == 0) begin
        chk("unexpected_write", {14'd0, sram_addr}, 32'hFFFF_FFFF);
      end else begin
        e = exp_wr_q.pop_front();
        chk("wr_addr", {14'd0, sram_addr}, {14'd0, e[33:16]});
        chk("wr_data", {16'd0, sram_dq_out}, {16'd0, e[15:0]});
        chk("wr_oe", {31'd0, sram_dq_oe}, 32'd1);
      end
    end
  end

  task automatic preload(input int k, input logic [31:0] w);
    sram_mem[2*k]   = w[15:0];
    sram_mem[2*k+1] = w[31:16];
    ref_word[k]     = w;
  endtask

  task automatic push_writes(input int k, input logic [31:0] d, input bit high_too);
    int n;
    n = (W == 1) ? 1 : W - 1;
    for (int i = 0; i < n; i++) exp_wr_q.push_back({18'(2*k), d[15:0]});
    if (high_too)
      for (int i = 0; i < n; i++) exp_wr_q.push_back({18'(2*k+1), d[31:16]});
  endtask

  // driver: one instruction through the stage; returns after the DONE edge
  task automatic do_access(input bit rd, input bit wr, input int k,
                           input logic [31:0] addr, input logic [31:0] d,
                           input bit wb, input logic [3:0] dst);
    int n;
    mem_read_en = rd; mem_write_en = wr; alu_res = addr; val_Rm = d;
    wb_en_in = wb; dest_in = dst;
    if (rd || wr) begin
      if (wr) begin
        push_writes(k, d, 1'b1);
        ref_word[k] = d;
        exp_q.push_back(32'd0);
        exp_rd_q.push_back(1'b0);
      end else begin
        exp_q.push_back(ref_word[k]);
        exp_rd_q.push_back(1'b1);
        last_rd = ref_word[k];
      end
    end
    @(negedge clk);
    chk("pass_alu", alu_res_out, addr);
    chk("pass_ctl", {25'd0, dest, wb_en, mem_read_en_out, align_err},
        {25'd0, dst, wb, rd, 1'b0});
    if (rd || wr) begin
      chk("freeze_on_req", {31'd0, freeze}, 32'd1);
      n = 0;
      do begin
        @(posedge clk); #1; n++;
      end while (dbg_state != S_DONE && n < 50);
      if (n >= 50) chk("done_timeout", 32'(n), 32'(FRZ));
      @(posedge clk); #1;
    end else begin
      chk("idle_freeze", {31'd0, freeze}, 32'd0);
      chk("idle_bus", {13'd0, sram_addr, sram_we_n, sram_dq_oe},
          {13'd0, 18'd0, 1'b1, 1'b0});
      chk("mem_data_hold", mem_data, last_rd);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < 1024; i++) sram_mem[i] = '0;
    for (int k = 0; k < 16; k++) preload(k, $urandom);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_data", mem_data, 32'd0);
    chk("rst_bus", {12'd0, sram_addr, sram_dq_out[0], sram_we_n, sram_dq_oe},
        {12'd0, 18'd0, 1'b0, 1'b1, 1'b0});
    chk("rst_dq_out", {16'd0, sram_dq_out}, 32'd0);
    chk("rst_flags", {29'd0, freeze, align_err, dbg_state == S_IDLE}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // directed: store, load of preloaded words, back-to-back
    do_access(1'b0, 1'b1, 0, 32'd1024, 32'hDEADBEEF, 1'b0, 4'd1);
    preload(1, 32'h12345678);
    do_access(1'b1, 1'b0, 1, 32'd1028, 32'h0, 1'b1, 4'd2);
    do_access(1'b0, 1'b1, 7, 32'd1052, 32'hCAFE_F00D, 1'b0, 4'd3);
    do_access(1'b1, 1'b0, 7, 32'd1052, 32'h0, 1'b1, 4'd4);
    do_access(1'b0, 1'b0, 0, 32'h55, 32'h0, 1'b1, 4'd5);

    // randomized instruction mix
    for (int t = 0; t < 40; t++) begin
      int kind, k;
      kind = $urandom_range(0, 3);
      k = $urandom_range(0, 15);
      do_access(kind == 1, kind >= 2, k, 32'(BASE + 4 * k), $urandom,
                1'($urandom), 4'($urandom));
    end

    // reset during the high half of a store
    mem_read_en = 1'b0; mem_write_en = 1'b1; alu_res = 32'(BASE + 20);
    val_Rm = 32'hA5A5_5A5A;
    push_writes(5, 32'hA5A5_5A5A, 1'b0);
    ref_word[5][15:0] = 16'h5A5A;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (dbg_state != S_HIGH && n < 50);
    if (n >= 50) chk("high_timeout", 32'(n), 32'(W + 1));
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_bus", {29'd0, sram_we_n, sram_dq_oe, freeze}, 32'b100);
    chk("rst_mid_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    chk("rst_mid_addr", {14'd0, sram_addr}, 32'd0);
    mem_write_en = 1'b0;
    last_rd = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_idle", {29'd0, sram_we_n, sram_dq_oe, freeze}, 32'b100);
    end
    @(posedge clk); #1;
    do_access(1'b1, 1'b0, 5, 32'(BASE + 20), 32'h0, 1'b0, 4'd6);

`ifdef MEM_STAGE_ALIGN_CHECK_EN
    mem_read_en = 1'b1; alu_res = 32'd1026;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("align_err", {31'd0, align_err}, 32'd1);
      chk("align_freeze", {31'd0, freeze}, 32'd0);
      chk("align_bus", {13'd0, sram_addr, sram_we_n}, {13'd0, 18'd0, 1'b1});
      chk("align_mem_data", mem_data, last_rd);
    end
    @(posedge clk); #1;
    mem_read_en = 1'b0;
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    chk("exp_wr_q_empty", 32'(exp_wr_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
